// File: rtl/ace_ccu_snoop_req_gen.sv
// ace_ccu_snoop_req_gen
// ---------------------
// Per-initiator snoop front-end of the CCU, one instance per snoop
// interconnect input. It takes one coherent request and drives two things
// into the interconnect: a target selection mask on the sel handshake and an
// AC snoop. It then collects the merged CR response, forwards any CD burst to
// the requestor, and reports a one-shot result. The CCU uses that result to
// decide whether memory must be accessed. Only one request is outstanding at
// a time.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_*                         coherent request in (addr, snoop, prot, src mask)
//   sel_o / sel_valid_o / sel_ready_i
//                                 target mask (~req_src_i) to the interconnect
//   ac_*                          AC snoop channel out
//   cr_valid_i / cr_ready_o / cr_resp_i
//                                 merged CR response in
//   cd_valid_i / cd_ready_o / cd_data_i / cd_last_i
//                                 CD data in
//   data_valid_o / data_ready_i / data_o / data_last_o
//                                 forwarded CD data out
//   res_valid_o / res_ready_i / res_{hit,dirty,shared,err}_o
//                                 one-shot snoop result
//
// Handshake rule, applied to every channel: a transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is raised, the
// producer keeps the valid signal and its payload stable until that transfer
// happens.
//
// The FSM state is held in state_q, which is an enum of type state_e.
// The only outputs that are not driven straight from registers are the
// pass-through signals used in DATA.

module ace_ccu_snoop_req_gen #(
  parameter int unsigned NumOup    = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CdBeats   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // coherent request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [3:0]           req_snoop_i,
  input  logic [2:0]           req_prot_i,
  input  logic [NumOup-1:0]    req_src_i,
  // target selection
  output logic [NumOup-1:0]    sel_o,
  output logic                 sel_valid_o,
  input  logic                 sel_ready_i,
  // AC channel
  output logic                 ac_valid_o,
  input  logic                 ac_ready_i,
  output logic [AddrWidth-1:0] ac_addr_o,
  output logic [3:0]           ac_snoop_o,
  output logic [2:0]           ac_prot_o,
  // CR channel
  input  logic                 cr_valid_i,
  output logic                 cr_ready_o,
  input  logic [4:0]           cr_resp_i,
  // CD channel
  input  logic                 cd_valid_i,
  output logic                 cd_ready_o,
  input  logic [DataWidth-1:0] cd_data_i,
  input  logic                 cd_last_i,
  // forwarded data
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 data_last_o,
  // result
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic                 res_hit_o,
  output logic                 res_dirty_o,
  output logic                 res_shared_o,
  output logic                 res_err_o
);

  localparam int unsigned CntW = (CdBeats > 1) ? $clog2(CdBeats) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(CdBeats - 1);

  // Bit positions inside cr_resp_i
  localparam int unsigned RespDt     = 0;
  localparam int unsigned RespErr    = 1;
  localparam int unsigned RespDirty  = 2;
  localparam int unsigned RespShared = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    RESP   = 3'd2,
    DATA   = 3'd3,
    RESULT = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_ready_q, req_ready_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  logic [2:0]             prot_q, prot_d;
  logic [NumOup-1:0]      sel_q, sel_d;
  logic                   sel_done_q, sel_done_d;
  logic                   ac_done_q, ac_done_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   hit_q, hit_d;
  logic                   dirty_q, dirty_d;
  logic                   shared_q, shared_d;
  logic                   err_q, err_d;

  logic                   in_issue, in_data;
  logic                   req_hs, sel_hs, ac_hs, cr_hs, beat_hs, res_hs;
  logic [NumOup-1:0]      new_sel;

  // WasUnique is not needed to form the result.
  logic unused_was_unique;
  assign unused_was_unique = cr_resp_i[4];

  assign in_issue = (state_q == ISSUE);
  assign in_data  = (state_q == DATA);
  assign new_sel  = ~req_src_i;

  // Each issue-side valid is held until its own handshake, tracked by a
  // done flag. This lets sel and AC complete in either order or together.
  assign sel_valid_o  = in_issue & ~sel_done_q;
  assign ac_valid_o   = in_issue & ~ac_done_q;
  assign sel_o        = sel_q;
  assign ac_addr_o    = addr_q;
  assign ac_snoop_o   = snoop_q;
  assign ac_prot_o    = prot_q;

  assign req_ready_o  = req_ready_q;
  assign cr_ready_o   = (state_q == RESP);
  assign res_valid_o  = (state_q == RESULT);
  assign res_hit_o    = hit_q;
  assign res_dirty_o  = dirty_q;
  assign res_shared_o = shared_q;
  assign res_err_o    = err_q;

  // CD is passed straight through to the requestor while in DATA.
  assign data_valid_o = in_data & cd_valid_i;
  assign cd_ready_o   = in_data & data_ready_i;
  assign data_o       = in_data ? cd_data_i : '0;
  assign data_last_o  = in_data & cd_last_i;

  assign req_hs  = req_valid_i & req_ready_q;
  assign sel_hs  = sel_valid_o & sel_ready_i;
  assign ac_hs   = ac_valid_o & ac_ready_i;
  assign cr_hs   = cr_valid_i & cr_ready_o;
  assign beat_hs = data_valid_o & data_ready_i;
  assign res_hs  = res_valid_o & res_ready_i;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    snoop_d    = snoop_q;
    prot_d     = prot_q;
    sel_d      = sel_q;
    sel_done_d = sel_done_q;
    ac_done_d  = ac_done_q;
    cnt_d      = cnt_q;
    hit_d      = hit_q;
    dirty_d    = dirty_q;
    shared_d   = shared_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_hs) begin
          addr_d     = req_addr_i;
          snoop_d    = req_snoop_i;
          prot_d     = req_prot_i;
          sel_d      = new_sel;
          sel_done_d = 1'b0;
          ac_done_d  = 1'b0;
          hit_d      = 1'b0;
          dirty_d    = 1'b0;
          shared_d   = 1'b0;
          err_d      = 1'b0;
          // An empty target mask means there is nobody to snoop: report a miss.
          state_d    = (new_sel == '0) ? RESULT : ISSUE;
        end
      end

      ISSUE: begin
        sel_done_d = sel_done_q | sel_hs;
        ac_done_d  = ac_done_q | ac_hs;
        if (sel_done_d && ac_done_d) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (cr_hs) begin
          dirty_d  = cr_resp_i[RespDirty];
          shared_d = cr_resp_i[RespShared];
          err_d    = cr_resp_i[RespErr];
          hit_d    = cr_resp_i[RespDt] & ~cr_resp_i[RespErr];
          cnt_d    = '0;
          // An erroneous response that still announces data must have its
          // burst drained.
          state_d  = cr_resp_i[RespDt] ? DATA : RESULT;
        end
      end

      DATA: begin
        if (beat_hs) begin
          // Flag a burst that ends early, and one that runs past the
          // expected length. Beats are still forwarded until last.
          if (cd_last_i != (cnt_q == LastIdx)) begin
            err_d = 1'b1;
          end
          if (cnt_q != LastIdx) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if (cd_last_i) begin
            state_d = RESULT;
          end
        end
      end

      RESULT: begin
        if (res_hs) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered so that req_ready only rises in the cycle after IDLE is
    // re-entered, and stays low while in reset.
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      addr_q      <= '0;
      snoop_q     <= '0;
      prot_q      <= '0;
      sel_q       <= '0;
      sel_done_q  <= 1'b0;
      ac_done_q   <= 1'b0;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      dirty_q     <= 1'b0;
      shared_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      prot_q      <= prot_d;
      sel_q       <= sel_d;
      sel_done_q  <= sel_done_d;
      ac_done_q   <= ac_done_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      dirty_q     <= dirty_d;
      shared_q    <= shared_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: doc/ace_ccu_snoop_req_gen.md
Name: ace_ccu_snoop_req_gen

Overview:
- Per-initiator snoop front-end of the CCU; sits directly upstream of the snoop interconnect, one instance per interconnect input.
- Accepts one coherent request (address, snoop opcode, initiator mask) and drives two interconnect inputs: a target selection mask on the sel handshake, and an AC snoop on the AC channel.
- Collects the merged CR response and forwards any CD data burst to the requestor.
- Reports a one-shot result (hit/miss/dirty/shared/error) so the CCU can decide whether memory must be accessed.

Parameters:
- NumOup, 4, number of snooped ports (width of the selection mask).
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- CdBeats, 4, expected CD beats per snoop data transfer (cache line / DataWidth); must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  coherent request valid
- req_ready_o  out  1  request accepted
- req_addr_i  in  AddrWidth  line address
- req_snoop_i  in  4  AC snoop opcode
- req_prot_i  in  3  AC prot
- req_src_i  in  NumOup  one-hot mask of the initiator's own port (excluded from snoop)
- sel_o  out  NumOup  target mask = ~req_src_i (registered)
- sel_valid_o  out  1  sel valid
- sel_ready_i  in  1  sel accepted
- ac_valid_o  out  1  AC valid
- ac_ready_i  in  1  AC accepted
- ac_addr_o  out  AddrWidth  registered address
- ac_snoop_o  out  4  registered opcode
- ac_prot_o  out  3  registered prot
- cr_valid_i  in  1  merged CR valid
- cr_ready_o  out  1  CR ready
- cr_resp_i  in  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}, bit 0 = DataTransfer
- cd_valid_i  in  1  CD beat valid
- cd_ready_o  out  1  CD ready
- cd_data_i  in  DataWidth  CD data
- cd_last_i  in  1  CD last beat
- data_valid_o  out  1  forwarded data valid
- data_ready_i  in  1  forwarded data ready
- data_o  out  DataWidth  forwarded data
- data_last_o  out  1  forwarded last
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result accepted
- res_hit_o  out  1  snoop supplied data (DataTransfer and not Error)
- res_dirty_o  out  1  PassDirty
- res_shared_o  out  1  IsShared
- res_err_o  out  1  CR Error, or CD beat-count mismatch

Behaviour:
- Reset: FSM goes to IDLE. All valids/readies = 0. Registered fields = 0. Beat counter = 0. Result flags = 0.
- FSM states: IDLE, ISSUE, RESP, DATA, RESULT.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, register addr/snoop/prot and sel = ~req_src_i.
  - If sel == 0: go to RESULT with hit = dirty = shared = err = 0 (miss, no snoop issued).
  - Otherwise: go to ISSUE; sel_valid_o and ac_valid_o rise the next cycle.
- ISSUE:
  - sel_valid_o and ac_valid_o are asserted concurrently and tracked by independent done flags.
  - Each valid drops in the cycle after its own handshake.
  - Both handshakes may occur in the same cycle or in either order.
  - Payloads are held stable while valid.
  - Go to RESP when both are done.
- RESP:
  - cr_ready_o = 1. On handshake, latch dirty, shared, err = Error, and hit = DataTransfer & ~Error.
  - If DataTransfer = 1 (including with Error): go to DATA with counter = 0.
  - Otherwise: go to RESULT.
  - A CR arriving during ISSUE is not accepted (cr_ready_o = 0).
- DATA:
  - Combinational pass-through: data_valid_o = cd_valid_i, cd_ready_o = data_ready_i, data_o = cd_data_i, data_last_o = cd_last_i.
  - Each beat handshake increments the counter; the counter saturates at CdBeats-1.
  - cd_last_i on a beat other than index CdBeats-1 sets err.
  - Reaching index CdBeats-1 without last also sets err; forwarding continues until last.
  - On the last-beat handshake, go to RESULT.
- RESULT:
  - res_valid_o = 1 with flags held stable.
  - On res_ready_i, go to IDLE.
  - req_ready_o goes high again the following cycle (no back-to-back bypass).
- Throughput: one outstanding request.
- Minimum latency with sel = 0: request handshake -> res_valid_o in 1 cycle.
- Outputs are glitch-free from registers, except the DATA pass-through signals.
- Asynchronous reset mid-operation aborts any transaction: all valids drop immediately and the FSM returns to IDLE.

Test Plan:
- NumOup=4, req_src=4'b0001, addr=0x1000, snoop=0x1 -> sel_o=4'b1110 and AC addr 0x1000 both valid; sel_ready at cycle 0, ac_ready at cycle 3 -> RESP entered after the AC handshake; CR=5'b00000 -> result hit=0, err=0.
- CR=5'b00101 (DataTransfer, PassDirty), 4 CD beats D0..D3 with last on D3, data_ready toggling -> data_o sequence D0..D3 unchanged, last on D3; result hit=1, dirty=1, err=0.
- CD last on beat 1 of 4 -> forwarding stops after beat 1; result err=1, hit=1.
- CR=5'b00011 (DataTransfer + Error) -> burst consumed; result hit=0, err=1.
- req_src=4'b1111 -> no sel/AC valid ever asserted; res_valid one cycle after the request, all flags 0.
- rst_ni low during DATA beat 2 -> all valids 0 immediately; after release, req_ready_o=1 and a new request completes normally.
